// File: rtl/hqvga_pkg.sv
// Shared constants and fetch-state encoding for the HQVGA line scheduler
// and the line-buffer reader on the HDMI side.
package hqvga_pkg;

  localparam int SRC_W          = 160;
  localparam int SRC_H          = 120;
  localparam int SCALE          = 6;
  localparam int ADDR_W_DEFAULT = 15;

  localparam int X_W     = 8;
  localparam int REP_W   = 3;
  localparam int SRC_Y_W = $clog2(SRC_H + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/hqvga_row_fetch.sv
// Reads one source row over the req/ack port and streams it into the
// write side of the ping-pong line buffer, one pixel per accepted ack.
module hqvga_row_fetch
  import hqvga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              wr_bank,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              lb_we,
  output logic [8:0]        lb_waddr,
  output logic [7:0]        lb_wdata,
  output logic              last_ack
);

  logic [X_W-1:0] x;
  logic           ack_ok;

  // Acks outside an open request are ignored entirely.
  assign ack_ok   = mem_ack & mem_req;
  assign last_ack = ack_ok && (x == X_W'(SRC_W - 1));

  // An ack in the same cycle as an abort is still written; start beats abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      x        <= '0;
      lb_we    <= 1'b0;
      lb_waddr <= '0;
      lb_wdata <= '0;
    end else begin
      lb_we <= ack_ok;
      if (ack_ok) begin
        lb_waddr <= {wr_bank, x};
        lb_wdata <= mem_rdata;
      end
      if (start) begin
        mem_req  <= 1'b1;
        mem_addr <= start_addr;
        x        <= '0;
      end else if (abort) begin
        mem_req <= 1'b0;
        x       <= '0;
      end else if (ack_ok) begin
        x        <= x + X_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
        if (last_ack) begin
          mem_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hqvga_line_scheduler.sv
// Schedules one framebuffer row fetch every SCALE output lines and swaps
// the ping-pong line-buffer banks at line starts once a fetch has finished.
module hqvga_line_scheduler
  import hqvga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_frame_start,
  input  logic              I_line_start,
  input  logic              I_next_active,
  output logic              O_mem_req,
  output logic [ADDR_W-1:0] O_mem_addr,
  input  logic              I_mem_ack,
  input  logic [7:0]        I_mem_rdata,
  output logic              O_lb_we,
  output logic [8:0]        O_lb_waddr,
  output logic [7:0]        O_lb_wdata,
  output logic              O_rd_bank,
  output logic              O_busy,
  output logic              O_underrun
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [SRC_Y_W-1:0] src_y;
  logic [REP_W-1:0]   rep_cnt;
  logic [ADDR_W-1:0]  row_base;
  logic               wr_bank;
  logic               fetch_start;
  logic               fetch_abort;
  logic               do_swap;
  logic               do_underrun;
  logic               last_ack;
  logic               rep_wrap;

  assign rep_wrap = (rep_cnt == REP_W'(SCALE - 1));
  assign O_busy   = (state == FETCH);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame start dominates; a line start resolves swap/underrun before scheduling.
  always_comb begin
    state_next  = state;
    fetch_start = 1'b0;
    fetch_abort = 1'b0;
    do_swap     = 1'b0;
    do_underrun = 1'b0;
    if (I_frame_start) begin
      state_next  = IDLE;
      fetch_abort = 1'b1;
    end else if (I_line_start) begin
      do_swap     = (state == DONE);
      do_underrun = (state == FETCH);
      fetch_abort = (state == FETCH);
      fetch_start = I_next_active && (rep_cnt == '0) &&
                    (src_y < SRC_Y_W'(SRC_H));
      state_next  = fetch_start ? FETCH : IDLE;
    end else if ((state == FETCH) && last_ack) begin
      state_next = DONE;
    end
  end

  // row_base accumulates by SRC_W so no multiplier is needed for src_y*SRC_W.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      src_y      <= '0;
      rep_cnt    <= '0;
      row_base   <= '0;
      wr_bank    <= 1'b1;
      O_rd_bank  <= 1'b0;
      O_underrun <= 1'b0;
    end else begin
      O_underrun <= do_underrun;
      if (do_swap) begin
        O_rd_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
      if (I_frame_start) begin
        src_y    <= '0;
        rep_cnt  <= '0;
        row_base <= '0;
      end else if (I_line_start && I_next_active) begin
        rep_cnt <= rep_wrap ? '0 : rep_cnt + REP_W'(1);
        if (rep_wrap && (src_y < SRC_Y_W'(SRC_H))) begin
          src_y    <= src_y + SRC_Y_W'(1);
          row_base <= row_base + ADDR_W'(SRC_W);
        end
      end
    end
  end

  hqvga_row_fetch #(
    .ADDR_W(ADDR_W)
  ) u_row_fetch (
    .clk       (I_clk),
    .rst       (I_rst),
    .start     (fetch_start),
    .abort     (fetch_abort),
    .start_addr(row_base),
    .wr_bank   (wr_bank),
    .mem_ack   (I_mem_ack),
    .mem_rdata (I_mem_rdata),
    .mem_req   (O_mem_req),
    .mem_addr  (O_mem_addr),
    .lb_we     (O_lb_we),
    .lb_waddr  (O_lb_waddr),
    .lb_wdata  (O_lb_wdata),
    .last_ack  (last_ack)
  );

endmodule

// File: tb/tb_hqvga_line_scheduler.sv
// Bench for hqvga_line_scheduler: a framebuffer model with selectable ack
// behaviour, a write/handshake monitor, and per-scenario checking tasks.
module tb_hqvga_line_scheduler;

  localparam int SRC_W      = 160;
  localparam int SRC_H      = 120;
  localparam int SCALE      = 6;
  localparam int ADDR_W     = 15;
  localparam int LONG_LINE  = 175;
  localparam int SHORT_LINE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              next_active = 1'b0;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              lb_we;
  logic [8:0]        lb_waddr;
  logic [7:0]        lb_wdata;
  logic              rd_bank;
  logic              busy;
  logic              underrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:32767];
  int ack_mode = 0;
  int cyc = 0;
  int line_count = 0;
  int cur_idx = 0;

  int mon_writes, mon_underruns, mon_toggles, mon_bank_viol;
  int mon_req_rises, mon_req_cycles, mon_max_x, snap_req_cycles;
  logic [8:0]        wq_addr[$];
  logic [7:0]        wq_data[$];
  logic [ADDR_W-1:0] rq_addr[$];
  int                tq_idx[$];
  logic prev_req = 1'b0;
  logic prev_bank = 1'b0;

  hqvga_line_scheduler #(.ADDR_W(ADDR_W)) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_frame_start(frame_start),
    .I_line_start (line_start),
    .I_next_active(next_active),
    .O_mem_req    (mem_req),
    .O_mem_addr   (mem_addr),
    .I_mem_ack    (mem_ack),
    .I_mem_rdata  (mem_rdata),
    .O_lb_we      (lb_we),
    .O_lb_waddr   (lb_waddr),
    .O_lb_wdata   (lb_wdata),
    .O_rd_bank    (rd_bank),
    .O_busy       (busy),
    .O_underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Framebuffer model: 0 = ack every cycle, 1 = every 12th, 2 = random, 3 = never.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (ack_mode)
        0:       mem_ack = mem_req;
        1:       mem_ack = mem_req && (cyc % 12 == 0);
        2:       mem_ack = mem_req && ($urandom_range(1, 0) == 1);
        default: mem_ack = 1'b0;
      endcase
      mem_rdata = mem[mem_addr];
    end
  end

  // Observes writes, request rises, underrun pulses and display-bank toggles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (lb_we) begin
          mon_writes++;
          wq_addr.push_back(lb_waddr);
          wq_data.push_back(lb_wdata);
          if (lb_waddr[8] !== ~rd_bank) mon_bank_viol++;
          if (int'(lb_waddr[7:0]) > mon_max_x) mon_max_x = int'(lb_waddr[7:0]);
        end
        if (mem_req && !prev_req) begin
          mon_req_rises++;
          rq_addr.push_back(mem_addr);
        end
        if (mem_req) mon_req_cycles++;
        if (underrun) mon_underruns++;
        if (rd_bank !== prev_bank) begin
          mon_toggles++;
          tq_idx.push_back(cur_idx);
        end
      end
      prev_req  = mem_req;
      prev_bank = rd_bank;
    end
  end

  task automatic clear_mon();
    mon_writes = 0; mon_underruns = 0; mon_toggles = 0; mon_bank_viol = 0;
    mon_req_rises = 0; mon_req_cycles = 0; mon_max_x = -1; snap_req_cycles = -1;
    wq_addr.delete(); wq_data.delete(); rq_addr.delete(); tq_idx.delete();
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    line_count = 0;
  endtask

  task automatic do_line(input logic nxt, input int len);
    @(negedge clk);
    cur_idx = line_count;
    line_count++;
    line_start = 1'b1;
    next_active = nxt;
    @(negedge clk);
    line_start = 1'b0;
    next_active = 1'b0;
    repeat (len - 1) @(negedge clk);
  endtask

  // Line i (counting line starts with next_active) fetches row i/SCALE when i%SCALE==0.
  task automatic run_frame(input int n_active, input int long_len, input int short_len);
    pulse_frame_start();
    for (int i = 0; i <= n_active; i++) begin
      logic nxt;
      bit   fetch_here;
      if (i == SRC_H * SCALE) snap_req_cycles = mon_req_cycles;
      nxt = (i < n_active);
      fetch_here = nxt && (i % SCALE == 0) && (i / SCALE < SRC_H);
      do_line(nxt, fetch_here ? long_len : short_len);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: outputs %h, expected all zero",
               {mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_released: outputs %h, expected all zero",
               {mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun});
    end
  endtask

  task automatic test_full_frame();
    int bad_addr, bad_data, bad_idx, n;
    ack_mode = 0;
    clear_mon();
    run_frame(SRC_H * SCALE, LONG_LINE, SHORT_LINE);
    tests_run++;
    if (rq_addr.size() != SRC_H) begin
      tests_failed++;
      $display("[TB] FAIL full_fetch_count: got %0d, expected %0d", rq_addr.size(), SRC_H);
    end
    bad_addr = 0;
    for (int k = 0; k < rq_addr.size() && k < SRC_H; k++)
      if (int'(rq_addr[k]) != k * SRC_W) bad_addr++;
    tests_run++;
    if (bad_addr != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_fetch_addr: %0d wrong row addresses, expected 0", bad_addr);
    end
    tests_run++;
    if (mon_writes != SRC_W * SRC_H) begin
      tests_failed++;
      $display("[TB] FAIL full_write_count: got %0d, expected %0d", mon_writes, SRC_W * SRC_H);
    end
    bad_data = 0;
    n = (wq_data.size() < SRC_W * SRC_H) ? wq_data.size() : SRC_W * SRC_H;
    for (int i = 0; i < n; i++)
      if (wq_data[i] !== mem[i] || int'(wq_addr[i][7:0]) != i % SRC_W) bad_data++;
    tests_run++;
    if (bad_data != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_write_data: %0d wrong pixel writes, expected 0", bad_data);
    end
    tests_run++;
    if (mon_underruns != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_underrun: got %0d pulses, expected 0", mon_underruns);
    end
    tests_run++;
    if (mon_toggles != SRC_H) begin
      tests_failed++;
      $display("[TB] FAIL full_bank_toggles: got %0d, expected %0d", mon_toggles, SRC_H);
    end
    bad_idx = 0;
    foreach (tq_idx[i]) if (tq_idx[i] % SCALE != 1) bad_idx++;
    tests_run++;
    if (bad_idx != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_toggle_line: %0d toggles off the 6-line cadence, expected 0", bad_idx);
    end
    tests_run++;
    if (mon_bank_viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL full_bank_bit: %0d writes into display bank, expected 0", mon_bank_viol);
    end
  endtask

  task automatic test_underrun();
    ack_mode = 1;
    clear_mon();
    run_frame(3 * SCALE, 1650, SHORT_LINE);
    tests_run++;
    if (mon_underruns != 3) begin
      tests_failed++;
      $display("[TB] FAIL slow_underrun: got %0d pulses, expected 3", mon_underruns);
    end
    tests_run++;
    if (mon_toggles != 0) begin
      tests_failed++;
      $display("[TB] FAIL slow_bank_toggles: got %0d, expected 0", mon_toggles);
    end
    tests_run++;
    if (mon_max_x < 0 || mon_max_x > 137) begin
      tests_failed++;
      $display("[TB] FAIL slow_max_x: got %0d, expected 0..137", mon_max_x);
    end
    tests_run++;
    if (rq_addr.size() != 3 || int'(rq_addr[rq_addr.size() - 1]) != 2 * SRC_W) begin
      tests_failed++;
      $display("[TB] FAIL slow_fetches: got %0d fetches, expected 3 ending at %0d",
               rq_addr.size(), 2 * SRC_W);
    end
  endtask

  task automatic test_frame_line_collision();
    logic bank_before;
    ack_mode = 3;
    clear_mon();
    pulse_frame_start();
    do_line(1'b1, 20);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL collide_busy_before: got %b, expected 1", busy);
    end
    bank_before = rd_bank;
    frame_start = 1'b1;
    line_start = 1'b1;
    next_active = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    line_start = 1'b0;
    next_active = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mon_underruns != 0) begin
      tests_failed++;
      $display("[TB] FAIL collide_underrun: got %0d pulses, expected 0", mon_underruns);
    end
    tests_run++;
    if ({busy, mem_req} !== 2'b00 || rd_bank !== bank_before) begin
      tests_failed++;
      $display("[TB] FAIL collide_abort: busy/req %b%b bank %b, expected 00 bank %b",
               busy, mem_req, rd_bank, bank_before);
    end
    ack_mode = 0;
    clear_mon();
    line_count = 0;
    do_line(1'b1, LONG_LINE);
    tests_run++;
    if (rq_addr.size() != 1 || rq_addr[0] !== '0 || mon_writes != SRC_W) begin
      tests_failed++;
      $display("[TB] FAIL collide_restart: %0d fetches %0d writes, expected 1 fetch at 0 with %0d writes",
               rq_addr.size(), mon_writes, SRC_W);
    end
  endtask

  task automatic test_random_stalls();
    int bad, n;
    ack_mode = 2;
    clear_mon();
    run_frame(3 * SCALE, 500, SHORT_LINE);
    tests_run++;
    if (mon_writes != 3 * SRC_W) begin
      tests_failed++;
      $display("[TB] FAIL stall_write_count: got %0d, expected %0d", mon_writes, 3 * SRC_W);
    end
    bad = 0;
    n = (wq_data.size() < 3 * SRC_W) ? wq_data.size() : 3 * SRC_W;
    for (int i = 0; i < n; i++)
      if (wq_data[i] !== mem[i] || int'(wq_addr[i][7:0]) != i % SRC_W) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_write_data: %0d wrong pixel writes, expected 0", bad);
    end
    tests_run++;
    if (mon_bank_viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_bank_bit: %0d writes into display bank, expected 0", mon_bank_viol);
    end
    tests_run++;
    if (mon_toggles != 3 || mon_underruns != 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_swaps: %0d toggles %0d underruns, expected 3 and 0",
               mon_toggles, mon_underruns);
    end
  endtask

  task automatic test_extra_lines();
    ack_mode = 0;
    clear_mon();
    run_frame(750, LONG_LINE, SHORT_LINE);
    tests_run++;
    if (rq_addr.size() != SRC_H || int'(rq_addr[rq_addr.size() - 1]) != (SRC_H - 1) * SRC_W) begin
      tests_failed++;
      $display("[TB] FAIL extra_fetches: got %0d fetches, expected %0d ending at %0d",
               rq_addr.size(), SRC_H, (SRC_H - 1) * SRC_W);
    end
    tests_run++;
    if (snap_req_cycles < 0 || mon_req_cycles != snap_req_cycles) begin
      tests_failed++;
      $display("[TB] FAIL extra_req_after_last: got %0d request cycles past row %0d, expected 0",
               mon_req_cycles - snap_req_cycles, SRC_H);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int budget;
    ack_mode = 0;
    clear_mon();
    pulse_frame_start();
    do_line(1'b1, 1);
    budget = 0;
    while (mon_writes < 50 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    tests_run++;
    if (mon_writes < 50) begin
      tests_failed++;
      $display("[TB] FAIL midrst_reach_x50: got %0d writes, expected 50", mon_writes);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: outputs %h, expected all zero",
               {mem_req, mem_addr, lb_we, lb_waddr, lb_wdata, rd_bank, busy, underrun});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    pulse_frame_start();
    do_line(1'b1, LONG_LINE);
    tests_run++;
    if (rq_addr.size() != 1 || rq_addr[0] !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_restart_addr: %0d fetches, expected 1 at address 0", rq_addr.size());
    end
    tests_run++;
    if (wq_addr.size() == 0 || wq_addr[0] !== 9'h100 || wq_data[0] !== mem[0]) begin
      tests_failed++;
      $display("[TB] FAIL midrst_first_write: %0d writes, expected first at 0x100 with %h",
               wq_addr.size(), mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    clear_mon();
    test_reset();
    test_full_frame();
    test_underrun();
    test_frame_line_collision();
    test_random_stalls();
    test_extra_lines();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
